ram_clr_par: RTL

- Parametrised successor to the 4x16 single-port scratch RAM.
- Generic width and depth, selectable read-during-write mode, read-valid strobe, and a hardware clear sequencer that zeroes the array after reset or on request.
- Busy and error flags for the access path.
- Built-in LED heartbeat divider, so board bring-up still has a "clock alive" indicator.
- Sits between board-level switch/button logic and display logic as the general storage element.

---
 rtl/ram_clr_par.sv | 100 ++++++++++
 1 files changed

// File: rtl/ram_clr_par.sv
// rtl/ram_clr_par.sv - parametrised scratch RAM with clear sequencer and heartbeat divider
// Array is zeroed by a one-word-per-cycle sweep after reset or on clr; accesses are refused while sweeping.
module ram_clr_par #(
  parameter int DW       = 4,
  parameter int AW       = 4,
  parameter int RDW_MODE = 0,
  parameter int DIV_W    = 28,
  parameter int LED_BIT  = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr,
  input  logic          rd,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data,
  output logic [DW-1:0] q,
  output logic          q_valid,
  output logic          busy,
  output logic          err,
  input  logic          clr,
  output logic          led
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    q_q, q_d;
  logic             q_valid_q, q_valid_d;
  logic             err_q, err_d;
  logic [DIV_W-1:0] div_q;

  logic [DW-1:0]    mem [0:(1<<AW)-1];
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [DW-1:0]    mem_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    q_d       = q_q;
    q_valid_d = 1'b0;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr;
    mem_wdata = data;
    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        err_d     = wr | rd;
        if (cnt_q == '1) state_d = READY;
      end
      READY: begin
        mem_we = wr;
        if (rd) begin
          q_valid_d = 1'b1;
          // mem read is combinational, so it still returns the pre-write word here
          q_d = ((RDW_MODE != 0) && wr) ? data : mem[addr];
        end
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= CLEAR;
      cnt_q     <= '0;
      q_q       <= '0;
      q_valid_q <= 1'b0;
      err_q     <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      q_valid_q <= q_valid_d;
      err_q     <= err_d;
      div_q     <= div_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign q       = q_q;
  assign q_valid = q_valid_q;
  assign err     = err_q;
  assign busy    = (state_q == CLEAR);
  assign led     = div_q[LED_BIT];

endmodule
